// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the shared ALU and its Y/Z registers.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (illegal opcodes raise err instead of running).
module alu_op_sequencer #(
    parameter int OPW         = 5,
    parameter int MULDIV_WAIT = 2
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           ra_out,
    output logic           rb_out,
    output logic           Yin,
    output logic           ALUin,
    output logic [OPW-1:0] alu_control,
    output logic           Zin,
    output logic           ZLowout,
    output logic           ZHighout,
    output logic           rz_in,
    output logic           LOin,
    output logic           HIin,
    output logic [2:0]     dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_Y = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_CAPT   = 3'd4,
        S_WB_LO  = 3'd5,
        S_WB_HI  = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_DIV = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5'b10010);
    localparam logic [3:0]     WAIT_INIT = 4'(MULDIV_WAIT);

    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    function automatic logic is_legal(input logic [OPW-1:0] op);
        return (op >= OPW'(5'b00011) && op <= OPW'(5'b01011)) ||
               (op >= OPW'(5'b01111) && op <= OPW'(5'b10010));
    endfunction
`endif

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [OPW-1:0] op_q, op_d;
    // {busy, done, err, ra, rb, yin, aluin, zin, zlo, zhi, rz, lo, hi}
    logic [12:0]    out_q, out_d;
    logic           err_d;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    if (!is_legal(opcode)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD_Y;
                        op_d    = opcode;
                    end
`else
                    state_d = S_LOAD_Y;
                    op_d    = opcode;
`endif
                end
            end
            S_LOAD_Y: state_d = S_EXEC;
            S_EXEC: begin
                if (is_muldiv(op_q)) begin
                    if (MULDIV_WAIT == 0) begin
                        state_d = S_CAPT;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_CAPT;
            end
            S_CAPT:  state_d = S_WB_LO;
            S_WB_LO: state_d = is_muldiv(op_q) ? S_WB_HI : S_IDLE;
            S_WB_HI: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) op_d = '0;

        // Outputs are decoded from the state being entered so they appear registered.
        out_d     = '0;
        out_d[10] = err_d;
        out_d[12] = (state_d != S_IDLE);
        case (state_d)
            S_LOAD_Y: begin out_d[9] = 1'b1; out_d[7] = 1'b1; end
            S_EXEC:   begin out_d[6] = 1'b1; out_d[8] = !is_unary(op_d); end
            S_WAIT:   out_d[8] = !is_unary(op_d);
            S_CAPT:   out_d[5] = 1'b1;
            S_WB_LO: begin
                out_d[4] = 1'b1;
                if (is_muldiv(op_d)) out_d[1] = 1'b1;
                else begin out_d[2] = 1'b1; out_d[11] = 1'b1; end
            end
            S_WB_HI:  begin out_d[3] = 1'b1; out_d[0] = 1'b1; out_d[11] = 1'b1; end
            default:  ;
        endcase
    end

    assign {busy, done, err, ra_out, rb_out, Yin, ALUin, Zin,
            ZLowout, ZHighout, rz_in, LOin, HIin} = out_q;
    assign alu_control = op_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a schedule model predicts every output cycle and a
// small Y/Z/bus harness driven by the strobes checks the written-back data.
module tb_alu_op_sequencer;
  localparam int W  = 18;
  localparam int MW = 2;

  localparam logic [12:0] F_BUSY  = 13'h1000, F_DONE = 13'h0800, F_ERR = 13'h0400;
  localparam logic [12:0] F_RA    = 13'h0200, F_RB   = 13'h0100, F_YIN = 13'h0080;
  localparam logic [12:0] F_ALUIN = 13'h0040, F_ZIN  = 13'h0020, F_ZLO = 13'h0010;
  localparam logic [12:0] F_ZHI   = 13'h0008, F_RZ   = 13'h0004, F_LO  = 13'h0002;
  localparam logic [12:0] F_HI    = 13'h0001;

  logic clock = 1'b0;
  logic clear, start;
  logic [4:0] opcode;
  logic busy, done, err, ra_out, rb_out, Yin, ALUin, Zin, ZLowout, ZHighout;
  logic rz_in, LOin, HIin;
  logic [4:0] alu_control;
  logic [2:0] dbg_state;

  logic [31:0] a_in, b_in, reg_a, reg_b, y_r, bus;
  logic [63:0] alu_r, z_r;

  logic [W-1:0] exp_q[$];
  logic [32:0]  data_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_free = 0;

  alu_op_sequencer #(.OPW(5), .MULDIV_WAIT(MW)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .err(err), .ra_out(ra_out), .rb_out(rb_out),
    .Yin(Yin), .ALUin(ALUin), .alu_control(alu_control), .Zin(Zin),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .rz_in(rz_in), .LOin(LOin),
    .HIin(HIin), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0]  s;
    logic [63:0] t;
    s = b[4:0];
    case (op)
      5'h03: return {32'b0, a + b};
      5'h04: return {32'b0, a - b};
      5'h05: return {32'b0, a & b};
      5'h06: return {32'b0, a | b};
      5'h07: return {32'b0, a >> s};
      5'h08: return {32'b0, 32'($signed(a) >>> s)};
      5'h09: return {32'b0, a << s};
      5'h0A: begin t = {a, a} >> s; return {32'b0, t[31:0]}; end
      5'h0B: begin t = {a, a} << s; return {32'b0, t[63:32]}; end
      5'h0F: return 64'(a) * 64'(b);
      5'h10: return (b == 0) ? 64'd0 : {a % b, a / b};
      5'h11: return {32'b0, 32'd0 - a};
      5'h12: return {32'b0, ~a};
      default: return 64'd0;
    endcase
  endfunction

  // Reference schedule: one accepted op expands into its full per-cycle output pattern.
  task automatic model_accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic legal, unary, md;
    logic [63:0] res;
    int n;
    legal = op inside {5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
                       5'h0F, 5'h10, 5'h11, 5'h12};
    unary = (op == 5'h11) || (op == 5'h12);
    md    = (op == 5'h0F) || (op == 5'h10);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (!legal) begin
      exp_q.push_back({F_ERR, 5'd0});
      next_free = cyc + 1;
      return;
    end
`endif
    reg_a = a;
    reg_b = b;
    res = ref_alu(op, a, b);
    n = exp_q.size();
    exp_q.push_back({F_BUSY | F_RA | F_YIN, op});
    exp_q.push_back({F_BUSY | F_ALUIN | (unary ? 13'h0 : F_RB), op});
    if (md) begin
      for (int i = 0; i < MW; i++) exp_q.push_back({F_BUSY | F_RB, op});
      exp_q.push_back({F_BUSY | F_ZIN, op});
      exp_q.push_back({F_BUSY | F_ZLO | F_LO, op});
      exp_q.push_back({F_BUSY | F_ZHI | F_HI | F_DONE, op});
      data_q.push_back({1'b1, res[31:0]});
      data_q.push_back({1'b1, res[63:32]});
    end else begin
      exp_q.push_back({F_BUSY | F_ZIN, op});
      exp_q.push_back({F_BUSY | F_ZLO | F_RZ | F_DONE, op});
      data_q.push_back({legal, res[31:0]});
    end
    next_free = cyc + (exp_q.size() - n) + 1;
  endtask

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (clear) next_free = 0;
    else if (start && cyc >= next_free) model_accept(opcode, a_in, b_in);
  end

  // Datapath harness: registers and bus reacting to the sequencer's strobes.
  always_comb begin
    bus = 32'd0;
    if (ra_out)   bus = reg_a;
    if (rb_out)   bus = reg_b;
    if (ZLowout)  bus = z_r[31:0];
    if (ZHighout) bus = z_r[63:32];
  end

  always @(negedge clock) begin
    if (Yin)   y_r = bus;
    if (ALUin) alu_r = ref_alu(alu_control, y_r, bus);
    if (Zin)   z_r = alu_r;
  end

  // Monitor: compare every cycle's outputs and every writeback's bus value.
  always @(posedge clock) begin
    logic [W-1:0] act, expv;
    logic [32:0]  d;
    #3;
    act = {busy, done, err, ra_out, rb_out, Yin, ALUin, Zin, ZLowout, ZHighout,
           rz_in, LOin, HIin, alu_control};
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL outputs cyc=%0d act=%b exp=%b", cyc, act, expv);
    end
    checks++;
    if (32'(ra_out) + 32'(rb_out) + 32'(ZLowout) + 32'(ZHighout) > 1) begin
      errors++;
      $display("FAIL bus_excl cyc=%0d ra=%b rb=%b zlo=%b zhi=%b", cyc, ra_out, rb_out,
               ZLowout, ZHighout);
    end
    if (rz_in || LOin || HIin) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++;
        $display("FAIL wb_data cyc=%0d unexpected writeback bus=%h", cyc, bus);
      end else begin
        d = data_q.pop_front();
        if (d[32] && bus !== d[31:0]) begin
          errors++;
          $display("FAIL wb_data cyc=%0d bus=%h exp=%h", cyc, bus, d[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; opcode = op; a_in = a; b_in = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_quiet(input string name);
    logic [W-1:0] act;
    act = {busy, done, err, ra_out, rb_out, Yin, ALUin, Zin, ZLowout, ZHighout,
           rz_in, LOin, HIin, alu_control};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s act=%b exp=0", name, act);
    end
  endtask

  logic [4:0] ops [14] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                           5'h0B, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h1F};

  initial begin
    clear = 1'b1; start = 1'b0; opcode = '0; a_in = '0; b_in = '0;
    reg_a = '0; reg_b = '0; y_r = '0; alu_r = '0; z_r = '0;
    idle(3);
    #1 check_quiet("reset");
    @(negedge clock);
    clear = 1'b0;

    issue(5'h03, 32'd5, 32'd7);            idle(8);
    issue(5'h0F, 32'h10000, 32'h10000);    idle(10);
    issue(5'h12, 32'd0, 32'd9);            idle(8);

    // Abort a div while it sits in WAIT; no writeback may follow.
    issue(5'h10, 32'd100, 32'd7);
    idle(2);
    clear = 1'b1;
    exp_q.delete();
    data_q.delete();
    #1 check_quiet("clear_abort");
    @(negedge clock);
    clear = 1'b0;
    idle(4);
    issue(5'h10, 32'd100, 32'd7);          idle(10);

    // Start held high: back-to-back adds, start ignored while busy.
    @(negedge clock);
    start = 1'b1; opcode = 5'h03; a_in = 32'd40; b_in = 32'd2;
    idle(16);
    start = 1'b0;
    idle(8);

    issue(5'h1F, 32'd1, 32'd2);            idle(8);

    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      start  = ($urandom_range(0, 2) == 0);
      opcode = ops[$urandom_range(0, 13)];
      a_in   = $urandom;
      b_in   = $urandom;
      if (b_in == 0) b_in = 32'd1;
    end
    start = 1'b0;
    idle(20);

    checks++;
    if (exp_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL drain exp_left=%0d data_left=%0d exp=0", exp_q.size(), data_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
